// File: rtl/cirno9_iob_slave.sv
// cirno9_iob_slave
//   IO-bus responder for the core's load/store port. Terminates val/rdy
//   requests and hosts a 64-bit machine timer with compare interrupt, a
//   scratch register and a byte-wide 8N1 UART transmitter.
//
// Parameters
//   WAIT_CYC  extra wait cycles between request accept and rdy (0..15)
//   BAUD_DIV  clk cycles per UART bit (>=2)
//
// Ports
//   clk              in   1   clock, rising edge
//   rst_n            in   1   asynchronous reset, active low
//   i_hs_ls4iob_val  in   1   request valid
//   o_hs_iob4ls_rdy  out  1   one-cycle completion pulse
//   i_iob_wen        in   4   byte write enables, 4'b0000 = read
//   i_adr            in   32  byte address, only adr[7:2] decoded
//   i_wdat           in   32  write data
//   o_iob_rdat       out  32  read data, non-zero only while rdy=1
//   o_irq_timer      out  1   level, mtime >= mtimecmp (unsigned)
//   o_uart_tx        out  1   UART TX line, idle high
module cirno9_iob_slave #(
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs_ls4iob_val,
    output logic        o_hs_iob4ls_rdy,
    input  logic [3:0]  i_iob_wen,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic [31:0] o_iob_rdat,
    output logic        o_irq_timer,
    output logic        o_uart_tx
);

    // Word indices (adr[7:2]) of the register map
    localparam logic [5:0] ADR_MTIME_LO = 6'h00;
    localparam logic [5:0] ADR_MTIME_HI = 6'h01;
    localparam logic [5:0] ADR_CMP_LO   = 6'h02;
    localparam logic [5:0] ADR_CMP_HI   = 6'h03;
    localparam logic [5:0] ADR_UART     = 6'h04;
    localparam logic [5:0] ADR_SCRATCH  = 6'h05;

    // WAIT lasts exactly WAIT_CYC cycles, so the counter starts one below it
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC == 32'd0) ? 4'd0 : 4'(WAIT_CYC - 32'd1);

    localparam int unsigned          BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(BAUD_DIV - 32'd1);

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_ACK  = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    // Replace only the byte lanes whose enable is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    bus_state_t     bus_state_r;
    bus_state_t     bus_state_nxt_s;
    logic [3:0]     wait_cnt_r;
    logic [3:0]     req_wen_r;
    logic [5:0]     req_adr_r;
    logic [31:0]    req_wdat_r;
    logic           rdy_r;
    logic [31:0]    rdat_r;
    logic           rdy_nxt_s;
    logic [31:0]    rdat_nxt_s;
    logic           accept_s;
    logic           commit_s;
    logic           wr_s;
    logic [5:0]     rd_idx_s;
    logic [31:0]    rd_data_s;

    logic [63:0]    mtime_r;
    logic [63:0]    mtimecmp_r;
    logic [31:0]    scratch_r;

    uart_state_t        uart_state_r;
    uart_state_t        uart_state_nxt_s;
    logic [BAUD_W-1:0]  baud_cnt_r;
    logic [BAUD_W-1:0]  baud_cnt_nxt_s;
    logic [2:0]         bit_idx_r;
    logic [2:0]         bit_idx_nxt_s;
    logic [7:0]         shift_r;
    logic [7:0]         shift_nxt_s;
    logic               tx_r;
    logic               tx_nxt_s;
    logic               baud_done_s;
    logic               uart_busy_s;
    logic               uart_load_s;

    logic               unused_adr_s;
    assign unused_adr_s = ^{i_adr[31:8], i_adr[1:0]};

    // Bus FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state_r <= BUS_IDLE;
        end else begin
            bus_state_r <= bus_state_nxt_s;
        end
    end

    // Bus FSM next-state logic; val is only looked at in IDLE
    always_comb begin
        bus_state_nxt_s = bus_state_r;
        case (bus_state_r)
            BUS_IDLE: begin
                if (i_hs_ls4iob_val) begin
                    bus_state_nxt_s = (WAIT_CYC == 32'd0) ? BUS_ACK : BUS_WAIT;
                end else begin
                    bus_state_nxt_s = BUS_IDLE;
                end
            end
            BUS_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    bus_state_nxt_s = BUS_ACK;
                end else begin
                    bus_state_nxt_s = BUS_WAIT;
                end
            end
            BUS_ACK:  bus_state_nxt_s = BUS_IDLE;
            default:  bus_state_nxt_s = BUS_IDLE;
        endcase
    end

    // Bus FSM outputs: rdy/rdat are registered on entry to ACK
    always_comb begin
        accept_s   = (bus_state_r == BUS_IDLE) && i_hs_ls4iob_val;
        commit_s   = (bus_state_r == BUS_ACK);
        rdy_nxt_s  = (bus_state_nxt_s == BUS_ACK);
        if (rdy_nxt_s) begin
            rdat_nxt_s = rd_data_s;
        end else begin
            rdat_nxt_s = 32'd0;
        end
    end

    assign wr_s = commit_s && (req_wen_r != 4'b0000);

    // With WAIT_CYC=0 the read mux is evaluated in IDLE, before the request is latched
    assign rd_idx_s = (bus_state_r == BUS_IDLE) ? i_adr[7:2] : req_adr_r;

    // Read data multiplexer
    always_comb begin
        case (rd_idx_s)
            ADR_MTIME_LO: rd_data_s = mtime_r[31:0];
            ADR_MTIME_HI: rd_data_s = mtime_r[63:32];
            ADR_CMP_LO:   rd_data_s = mtimecmp_r[31:0];
            ADR_CMP_HI:   rd_data_s = mtimecmp_r[63:32];
            ADR_UART:     rd_data_s = {31'd0, uart_busy_s};
            ADR_SCRATCH:  rd_data_s = scratch_r;
            default:      rd_data_s = 32'd0;
        endcase
    end

    // Request latch, wait counter and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
            req_wen_r  <= 4'd0;
            req_adr_r  <= 6'd0;
            req_wdat_r <= 32'd0;
            rdy_r      <= 1'b0;
            rdat_r     <= 32'd0;
        end else begin
            if (accept_s) begin
                req_wen_r  <= i_iob_wen;
                req_adr_r  <= i_adr[7:2];
                req_wdat_r <= i_wdat;
                wait_cnt_r <= WAIT_LOAD;
            end else if ((bus_state_r == BUS_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            rdy_r  <= rdy_nxt_s;
            rdat_r <= rdat_nxt_s;
        end
    end

    // Machine timer: a write to either half freezes the whole counter for that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_r <= 64'd0;
        end else if (wr_s && (req_adr_r == ADR_MTIME_LO)) begin
            mtime_r[31:0] <= merge_bytes(mtime_r[31:0], req_wdat_r, req_wen_r);
        end else if (wr_s && (req_adr_r == ADR_MTIME_HI)) begin
            mtime_r[63:32] <= merge_bytes(mtime_r[63:32], req_wdat_r, req_wen_r);
        end else begin
            mtime_r <= mtime_r + 64'd1;
        end
    end

    // Timer compare and scratch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            scratch_r  <= 32'd0;
        end else if (wr_s) begin
            case (req_adr_r)
                ADR_CMP_LO:  mtimecmp_r[31:0]  <= merge_bytes(mtimecmp_r[31:0], req_wdat_r, req_wen_r);
                ADR_CMP_HI:  mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], req_wdat_r, req_wen_r);
                ADR_SCRATCH: scratch_r         <= merge_bytes(scratch_r, req_wdat_r, req_wen_r);
                default:     scratch_r         <= scratch_r;
            endcase
        end
    end

    assign o_irq_timer = (mtime_r >= mtimecmp_r);

    assign baud_done_s = (baud_cnt_r == BAUD_LAST);
    assign uart_busy_s = (uart_state_r != U_IDLE);
    // Writes while a frame is in flight are dropped
    assign uart_load_s = wr_s && (req_adr_r == ADR_UART) && req_wen_r[0] && !uart_busy_s;

    // UART FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_state_r <= U_IDLE;
        end else begin
            uart_state_r <= uart_state_nxt_s;
        end
    end

    // UART FSM next-state logic
    always_comb begin
        uart_state_nxt_s = uart_state_r;
        case (uart_state_r)
            U_IDLE: begin
                if (uart_load_s) begin
                    uart_state_nxt_s = U_START;
                end else begin
                    uart_state_nxt_s = U_IDLE;
                end
            end
            U_START: begin
                if (baud_done_s) begin
                    uart_state_nxt_s = U_DATA;
                end else begin
                    uart_state_nxt_s = U_START;
                end
            end
            U_DATA: begin
                if (baud_done_s && (bit_idx_r == 3'd7)) begin
                    uart_state_nxt_s = U_STOP;
                end else begin
                    uart_state_nxt_s = U_DATA;
                end
            end
            U_STOP: begin
                if (baud_done_s) begin
                    uart_state_nxt_s = U_IDLE;
                end else begin
                    uart_state_nxt_s = U_STOP;
                end
            end
            default: uart_state_nxt_s = U_IDLE;
        endcase
    end

    // UART outputs: baud/bit counters, shifter and the next line level
    always_comb begin
        baud_cnt_nxt_s = baud_cnt_r;
        bit_idx_nxt_s  = bit_idx_r;
        shift_nxt_s    = shift_r;
        if (uart_load_s) begin
            baud_cnt_nxt_s = {BAUD_W{1'b0}};
            bit_idx_nxt_s  = 3'd0;
            shift_nxt_s    = req_wdat_r[7:0];
        end else if (uart_state_r == U_IDLE) begin
            baud_cnt_nxt_s = {BAUD_W{1'b0}};
        end else if (baud_done_s) begin
            baud_cnt_nxt_s = {BAUD_W{1'b0}};
            if (uart_state_r == U_DATA) begin
                shift_nxt_s   = {1'b0, shift_r[7:1]};
                bit_idx_nxt_s = bit_idx_r + 3'd1;
            end else begin
                bit_idx_nxt_s = 3'd0;
            end
        end else begin
            baud_cnt_nxt_s = baud_cnt_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end

        case (uart_state_nxt_s)
            U_START: tx_nxt_s = 1'b0;
            U_DATA:  tx_nxt_s = shift_nxt_s[0];
            U_STOP:  tx_nxt_s = 1'b1;
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // UART datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
        end
    end

    assign o_hs_iob4ls_rdy = rdy_r;
    assign o_iob_rdat      = rdat_r;
    assign o_uart_tx       = tx_r;

endmodule

// File: tb/tb_cirno9_iob_slave.sv
module tb_cirno9_iob_slave;

    logic        clk;
    logic        rst_n;

    logic        val_a, rdy_a, irq_a, tx_a;
    logic [3:0]  wen_a;
    logic [31:0] adr_a, wdat_a, rdat_a;

    logic        val_b, rdy_b, irq_b, tx_b;
    logic [3:0]  wen_b;
    logic [31:0] adr_b, wdat_b, rdat_b;

    int n_checks;
    int n_err;

    cirno9_iob_slave #(.WAIT_CYC(1), .BAUD_DIV(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_hs_ls4iob_val (val_a),
        .o_hs_iob4ls_rdy (rdy_a),
        .i_iob_wen       (wen_a),
        .i_adr           (adr_a),
        .i_wdat          (wdat_a),
        .o_iob_rdat      (rdat_a),
        .o_irq_timer     (irq_a),
        .o_uart_tx       (tx_a)
    );

    cirno9_iob_slave #(.WAIT_CYC(0), .BAUD_DIV(4)) dut_w0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_hs_ls4iob_val (val_b),
        .o_hs_iob4ls_rdy (rdy_b),
        .i_iob_wen       (wen_b),
        .i_adr           (adr_b),
        .i_wdat          (wdat_b),
        .o_iob_rdat      (rdat_b),
        .o_irq_timer     (irq_b),
        .o_uart_tx       (tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus transaction; starts and ends 1 time unit after a rising edge
    task automatic bus(input int sel, input logic [3:0] wen, input logic [31:0] adr,
                       input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
        logic got;
        got  = 1'b0;
        lat  = 0;
        rdat = 32'd0;
        if (sel == 0) begin
            val_a = 1'b1; wen_a = wen; adr_a = adr; wdat_a = wdat;
        end else begin
            val_b = 1'b1; wen_b = wen; adr_b = adr; wdat_b = wdat;
        end
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk);
            #1;
            if ((sel == 0) ? rdy_a : rdy_b) begin
                got  = 1'b1;
                lat  = c;
                rdat = (sel == 0) ? rdat_a : rdat_b;
            end
        end
        val_a = 1'b0;
        val_b = 1'b0;
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL bus_timeout: no rdy for adr %h within 40 cycles", adr);
        end else begin
            @(posedge clk);
            #1;
            check("rdy_pulse_width", {31'd0, (sel == 0) ? rdy_a : rdy_b}, 32'd0);
            check("rdat_outside_ack", (sel == 0) ? rdat_a : rdat_b, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          model;
        logic [9:0]  frame;

        n_checks = 0;
        n_err    = 0;
        val_a = 1'b0; wen_a = 4'd0; adr_a = 32'd0; wdat_a = 32'd0;
        val_b = 1'b0; wen_b = 4'd0; adr_b = 32'd0; wdat_b = 32'd0;

        vecs[0]  = '{4'b0101, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{4'b0000, 32'h0000_0014, 32'h0000_0000, 1'b1, 32'h00AD_00EF};
        vecs[2]  = '{4'b1010, 32'h0000_0014, 32'h1122_3344, 1'b0, 32'h0000_0000};
        vecs[3]  = '{4'b0000, 32'h0000_0014, 32'h0000_0000, 1'b1, 32'h11AD_33EF};
        vecs[4]  = '{4'b0000, 32'h0000_0040, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[5]  = '{4'b1111, 32'h0000_0040, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        vecs[6]  = '{4'b0000, 32'h0000_0014, 32'h0000_0000, 1'b1, 32'h11AD_33EF};
        vecs[7]  = '{4'b0000, 32'h0000_0018, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[8]  = '{4'b0000, 32'h0000_0008, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF};
        vecs[9]  = '{4'b0000, 32'h0000_000C, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF};
        vecs[10] = '{4'b0000, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{4'b0000, 32'h0000_0054, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[12] = '{4'b0000, 32'h0000_0114, 32'h0000_0000, 1'b1, 32'h11AD_33EF};
        vecs[13] = '{4'b0000, 32'h0000_0017, 32'h0000_0000, 1'b1, 32'h11AD_33EF};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", {31'd0, rdy_a}, 32'd0);
        check("reset_rdat", rdat_a, 32'd0);
        check("reset_tx", {31'd0, tx_a}, 32'd1);
        check("reset_irq", {31'd0, irq_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First read after reset: latency and value
        bus(0, 4'b0000, 32'h14, 32'd0, rd, lat);
        check("first_read_lat", 32'(lat), 32'd2);
        check("first_read_rdat", rd, 32'd0);

        // Table of register map vectors
        for (int i = 0; i < 14; i++) begin
            bus(0, vecs[i].wen, vecs[i].adr, vecs[i].wdat, rd, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rdat", i), rd, vecs[i].exp);
            end
        end

        // Zero-wait instance: rdy one cycle after val, back-to-back
        bus(1, 4'b0000, 32'h14, 32'd0, rd, lat);
        check("w0_read_lat", 32'(lat), 32'd1);
        check("w0_read_rdat", rd, 32'd0);
        bus(1, 4'b1111, 32'h14, 32'hCAFE_F00D, rd, lat);
        bus(1, 4'b0000, 32'h14, 32'd0, rd, lat);
        check("w0_readback_lat", 32'(lat), 32'd1);
        check("w0_readback", rd, 32'hCAFE_F00D);

        // Timer carry LO->HI and no increment on the write edge
        bus(0, 4'b1111, 32'h04, 32'h0000_0000, rd, lat);
        bus(0, 4'b1111, 32'h00, 32'hFFFF_FFFE, rd, lat);
        bus(0, 4'b0000, 32'h00, 32'd0, rd, lat);
        check("mtime_lo_after_write", rd, 32'hFFFF_FFFF);
        bus(0, 4'b0000, 32'h04, 32'd0, rd, lat);
        check("mtime_hi_carry", rd, 32'h0000_0001);
        bus(0, 4'b0000, 32'h00, 32'd0, rd, lat);
        check("mtime_lo_after_carry", rd, 32'h0000_0005);

        // 64-bit wrap
        bus(0, 4'b1111, 32'h04, 32'hFFFF_FFFF, rd, lat);
        bus(0, 4'b1111, 32'h00, 32'hFFFF_FFFF, rd, lat);
        bus(0, 4'b0000, 32'h04, 32'd0, rd, lat);
        check("mtime_hi_wrap", rd, 32'h0000_0000);
        bus(0, 4'b0000, 32'h00, 32'd0, rd, lat);
        check("mtime_lo_wrap", rd, 32'h0000_0003);

        // Compare and interrupt
        bus(0, 4'b1111, 32'h0C, 32'h0000_0000, rd, lat);
        bus(0, 4'b1111, 32'h04, 32'h0000_0000, rd, lat);
        bus(0, 4'b1111, 32'h00, 32'h0000_0000, rd, lat);
        bus(0, 4'b1111, 32'h08, 32'd20, rd, lat);
        model = 3;
        check("irq_before", {31'd0, irq_a}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            model++;
            check($sformatf("irq_at_mtime_%0d", model), {31'd0, irq_a}, {31'd0, (model >= 20)});
        end
        bus(0, 4'b1111, 32'h0C, 32'hFFFF_FFFF, rd, lat);
        check("irq_cleared_by_cmp", {31'd0, irq_a}, 32'd0);

        // UART write without wen[0] does nothing
        bus(0, 4'b0010, 32'h10, 32'h0000_5555, rd, lat);
        check("uart_no_wen0_tx", {31'd0, tx_a}, 32'd1);
        bus(0, 4'b0000, 32'h10, 32'd0, rd, lat);
        check("uart_no_wen0_busy", rd, 32'd0);

        // UART frame 0x55, busy mid-frame, second write dropped
        frame = {1'b1, 8'h55, 1'b0};
        bus(0, 4'b0001, 32'h10, 32'h0000_0055, rd, lat);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    check($sformatf("uart_tx_cyc%0d", i), {31'd0, tx_a}, {31'd0, frame[i/4]});
                    if (i < 39) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                logic [31:0] rd2;
                int          lat2;
                repeat (8) @(posedge clk);
                #1;
                bus(0, 4'b0000, 32'h10, 32'd0, rd2, lat2);
                check("uart_busy_mid", rd2, 32'd1);
                bus(0, 4'b0001, 32'h10, 32'h0000_00AA, rd2, lat2);
            end
        join
        bus(0, 4'b0000, 32'h10, 32'd0, rd, lat);
        check("uart_busy_after", rd, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("uart_idle_after_%0d", i), {31'd0, tx_a}, 32'd1);
            @(posedge clk);
            #1;
        end

        // Reset during WAIT of a SCRATCH write and mid UART frame
        bus(0, 4'b1111, 32'h14, 32'h0000_0000, rd, lat);
        bus(0, 4'b0001, 32'h10, 32'h0000_0000, rd, lat);
        repeat (10) @(posedge clk);
        #1;
        check("uart_tx_mid_zero", {31'd0, tx_a}, 32'd0);
        val_a = 1'b1; wen_a = 4'b1111; adr_a = 32'h14; wdat_a = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("rst_wait_rdy", {31'd0, rdy_a}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_tx_now", {31'd0, tx_a}, 32'd1);
        check("rst_rdy_now", {31'd0, rdy_a}, 32'd0);
        val_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold_rdy%0d", i), {31'd0, rdy_a}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus(0, 4'b0000, 32'h14, 32'd0, rd, lat);
        check("rst_scratch_zero", rd, 32'd0);
        bus(0, 4'b0000, 32'h10, 32'd0, rd, lat);
        check("rst_uart_idle", rd, 32'd0);
        bus(0, 4'b0000, 32'h0C, 32'd0, rd, lat);
        check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        check("rst_tx_idle", {31'd0, tx_a}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
